// File: rtl/muskbus_arbiter.sv
// N-to-1 MUSKBUS arbiter: round-robin grant held per burst, in-order response routing via an owner FIFO.
// Optional per-grant quota release enabled by defining MUSKBUS_ARB_QUOTA_EN.

package MUSKBUS;
  typedef struct packed {
    logic        bid;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
  } resp_t;
endpackage

module muskbus_arbiter #(
  parameter int N           = 2,
  parameter int OUTSTANDING = 4,
  parameter int MAX_TXN     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  MUSKBUS::req_t  [N-1:0] bottom_reqs,
  output logic           [N-1:0] bottom_reqacks,
  output MUSKBUS::resp_t [N-1:0] bottom_resps,
  input  logic           [N-1:0] bottom_respacks,
  output MUSKBUS::req_t          top_req,
  input  logic                   top_reqack,
  input  MUSKBUS::resp_t         top_resp,
  output logic                   top_respack
);

  localparam int OW = $clog2(N);
  localparam int PW = $clog2(OUTSTANDING);
  localparam int FW = $clog2(OUTSTANDING + 1);

  if (N < 2 || OUTSTANDING < 2 || (OUTSTANDING & (OUTSTANDING - 1)) != 0 || MAX_TXN < 1) begin : g_bad_params
    $error("muskbus_arbiter: invalid parameter set");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_ff;
  logic [OW-1:0]   owner_ff;
  logic [OW-1:0]   last_ff;

  logic [OW-1:0]   fifo_mem [OUTSTANDING];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [FW-1:0]   fifo_cnt;
  logic            fifo_full;
  logic            fifo_empty;
  logic [OW-1:0]   head;

  logic [N-1:0]    bids;
  logic            owner_bid;
  logic            accept;
  logic            pop;
  logic            release_grant;
  logic            quota_release;
  logic            pick_valid;
  logic [OW-1:0]   pick;

  assign fifo_full  = (fifo_cnt == FW'(OUTSTANDING));
  assign fifo_empty = (fifo_cnt == '0);
  assign head       = fifo_mem[rd_ptr];

  always_comb begin
    bids = '0;
    for (int unsigned i = 0; i < N; i++) begin
      bids[i] = bottom_reqs[i].bid;
    end
  end

  assign owner_bid = bids[owner_ff];
  assign accept    = (state_ff == BUSY) && owner_bid && top_reqack && !fifo_full;
  assign pop       = !fifo_empty && top_resp.valid && top_respack;

  // Round-robin search starting just after the last grantee; last_ff+k < 2N so one wrap suffices.
  always_comb begin
    int unsigned idx;
    logic [OW-1:0] cand;
    pick_valid = 1'b0;
    pick       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = int'(last_ff) + k;
      if (idx >= N) idx = idx - N;
      cand = OW'(idx);
      if (!pick_valid && bids[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

`ifdef MUSKBUS_ARB_QUOTA_EN
  localparam int CW = $clog2(MAX_TXN + 1);

  logic [CW-1:0] txn_cnt;
  logic [CW-1:0] txn_next;
  logic          other_bid;

  assign other_bid     = |(bids & ~({{(N-1){1'b0}}, 1'b1} << owner_ff));
  // Count saturates at MAX_TXN so a lone master keeps the grant indefinitely.
  assign txn_next      = (accept && txn_cnt != CW'(MAX_TXN)) ? txn_cnt + CW'(1) : txn_cnt;
  assign quota_release = accept && (txn_next == CW'(MAX_TXN)) && other_bid;
`else
  assign quota_release = 1'b0;
`endif

  assign release_grant = !owner_bid || quota_release;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_ff <= IDLE;
      owner_ff <= '0;
      last_ff  <= OW'(N - 1);
`ifdef MUSKBUS_ARB_QUOTA_EN
      txn_cnt  <= '0;
`endif
    end else begin
      case (state_ff)
        IDLE: begin
          if (pick_valid) begin
            state_ff <= BUSY;
            owner_ff <= pick;
            last_ff  <= pick;
`ifdef MUSKBUS_ARB_QUOTA_EN
            txn_cnt  <= '0;
`endif
          end
        end
        BUSY: begin
`ifdef MUSKBUS_ARB_QUOTA_EN
          txn_cnt <= txn_next;
`endif
          if (release_grant) state_ff <= IDLE;
        end
        default: state_ff <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= owner_ff;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      case ({accept, pop})
        2'b10:   fifo_cnt <= fifo_cnt + FW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - FW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_comb begin
    top_req        = '0;
    bottom_reqacks = '0;
    if (state_ff == BUSY) begin
      top_req = bottom_reqs[owner_ff];
      if (fifo_full) top_req.bid = 1'b0;
      bottom_reqacks[owner_ff] = top_reqack && !fifo_full;
    end
  end

  always_comb begin
    bottom_resps = '0;
    top_respack  = 1'b0;
    if (!fifo_empty) begin
      bottom_resps[head] = top_resp;
      top_respack        = bottom_respacks[head];
    end
  end

endmodule

// File: tb/tb_muskbus_arbiter.sv
// Bench for muskbus_arbiter: directed scenarios plus random traffic, checked against a queue-based model.
`timescale 1ns/1ps
module tb_muskbus_arbiter;
  localparam int N    = 4;
  localparam int OUT  = 4;
  localparam int MAXT = 3;
  localparam logic [31:0] BASE = 32'hA000_0000;

  logic                   clk = 1'b0;
  logic                   reset;
  MUSKBUS::req_t  [N-1:0] reqs;
  logic           [N-1:0] bottom_reqacks;
  MUSKBUS::resp_t [N-1:0] bottom_resps;
  logic           [N-1:0] respacks;
  MUSKBUS::req_t          top_req;
  logic                   top_reqack;
  MUSKBUS::resp_t         top_resp;
  logic                   top_respack;

  muskbus_arbiter #(.N(N), .OUTSTANDING(OUT), .MAX_TXN(MAXT)) dut (
    .clk(clk), .reset(reset),
    .bottom_reqs(reqs), .bottom_reqacks(bottom_reqacks),
    .bottom_resps(bottom_resps), .bottom_respacks(respacks),
    .top_req(top_req), .top_reqack(top_reqack),
    .top_resp(top_resp), .top_respack(top_respack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: grant flag, owner, last grantee, per-grant accept count, owner queue.
  bit m_busy;
  int m_owner, m_last, m_cnt;
  int q[$];

  MUSKBUS::req_t          s_req;
  logic [N-1:0]           s_acks;
  MUSKBUS::resp_t [N-1:0] s_resps;
  logic                   s_rack;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = N - 1; m_cnt = 0;
    q.delete();
  endtask

  task automatic cycle();
    MUSKBUS::req_t          e_req;
    logic [N-1:0]           e_ack;
    MUSKBUS::resp_t [N-1:0] e_resp;
    logic                   e_rack;
    bit acc, pop, rel, others, found;
    int idx;
    #2;
    e_req = '0; e_ack = '0; e_resp = '0; e_rack = 1'b0;
    if (m_busy) begin
      e_req = reqs[m_owner];
      if (q.size() == OUT) e_req.bid = 1'b0;
      if (top_reqack && q.size() < OUT) e_ack[m_owner] = 1'b1;
    end
    if (q.size() > 0) begin
      e_resp[q[0]] = top_resp;
      e_rack = respacks[q[0]];
    end
    s_req = top_req; s_acks = bottom_reqacks; s_resps = bottom_resps; s_rack = top_respack;
    chk("top_req", 256'(top_req), 256'(e_req));
    chk("reqacks", 256'(bottom_reqacks), 256'(e_ack));
    chk("resps", 256'(bottom_resps), 256'(e_resp));
    chk("respack", 256'(top_respack), 256'(e_rack));
    if (reset) begin
      model_reset();
    end else begin
      pop = (q.size() > 0) && top_resp.valid && respacks[q[0]];
      acc = m_busy && reqs[m_owner].bid && top_reqack && (q.size() < OUT);
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(m_owner);
      if (!m_busy) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (!found && reqs[idx].bid) begin
            found = 1; m_busy = 1; m_owner = idx; m_last = idx; m_cnt = 0;
          end
        end
      end else begin
        others = 0;
        for (int j = 0; j < N; j++) if (j != m_owner && reqs[j].bid) others = 1;
        if (acc && m_cnt < MAXT) m_cnt++;
        rel = !reqs[m_owner].bid;
`ifdef MUSKBUS_ARB_QUOTA_EN
        if (acc && m_cnt == MAXT && others) rel = 1;
`endif
        if (rel) m_busy = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) reqs[i].bid = 1'b0;
    top_resp.valid = 1'b1;
    respacks = '1;
    for (int i = 0; i < OUT + 3; i++) cycle();
    top_resp.valid = 1'b0;
    respacks = '0;
  endtask

  initial begin
    int acc_n;
    int exp_port[3];
    MUSKBUS::resp_t [N-1:0] er;

    reset = 1'b1;
    top_reqack = 1'b0;
    top_resp = '0;
    respacks = '0;
    for (int i = 0; i < N; i++) begin
      reqs[i] = '0;
      reqs[i].addr  = BASE + 32'(i);
      reqs[i].wdata = $urandom;
    end
    model_reset();
    @(posedge clk); #1;
    cycle(); cycle();
    chk("reset_top_req", 256'(s_req), 256'(0));
    chk("reset_resps", 256'(s_resps), 256'(0));
    reset = 1'b0;

    // Round-robin: ports 0 and 2 together.
    reqs[0].bid = 1; reqs[2].bid = 1;
    cycle();
    chk("rr_idle_bubble", 256'(s_req.bid), 256'(0));
    cycle();
    chk("rr_first_p0", 256'(s_req.addr), 256'(BASE));
    chk("rr_first_bid", 256'(s_req.bid), 256'(1));
    cycle();
    reqs[0].bid = 0;
    cycle(); cycle();
    chk("rr_release_idle", 256'(s_req), 256'(0));
    cycle();
    chk("rr_then_p2", 256'(s_req.addr), 256'(BASE + 2));
    reqs[2].bid = 0;
    cycle(); cycle();
    reqs[0].bid = 1; reqs[2].bid = 1;
    cycle(); cycle();
    chk("rr_again_p0", 256'(s_req.addr), 256'(BASE));
    reqs[0].bid = 0; reqs[2].bid = 0;
    cycle(); cycle();

    // Backpressure: FIFO depth limits accepts with no responses.
    reqs[1].bid = 1; top_reqack = 1;
    acc_n = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (s_acks[1] && s_req.bid) acc_n++;
    end
    chk("bp_accepts", 256'(acc_n), 256'(OUT));
    chk("bp_bid_low", 256'(s_req.bid), 256'(0));
    top_resp.valid = 1; top_resp.rdata = 32'h55; respacks = 4'b0010;
    cycle();
    top_resp.valid = 0; respacks = '0;
    acc_n = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (s_acks[1] && s_req.bid) acc_n++;
    end
    chk("bp_one_more", 256'(acc_n), 256'(1));
    drain();

    // Response ordering: p0 two requests, p1 one request.
    reqs[0].bid = 1; top_reqack = 1;
    cycle();
    cycle(); chk("ord_acc0a", 256'(s_acks), 256'(4'b0001));
    cycle(); chk("ord_acc0b", 256'(s_acks), 256'(4'b0001));
    reqs[0].bid = 0; reqs[1].bid = 1;
    cycle(); cycle();
    cycle(); chk("ord_acc1", 256'(s_acks), 256'(4'b0010));
    reqs[1].bid = 0;
    cycle();
    exp_port[0] = 0; exp_port[1] = 0; exp_port[2] = 1;
    respacks = '1; top_resp.valid = 1;
    for (int k = 0; k < 3; k++) begin
      top_resp.rdata = 32'(100 + k);
      cycle();
      er = '0;
      er[exp_port[k]].valid = 1'b1;
      er[exp_port[k]].rdata = 32'(100 + k);
      chk("ord_route", 256'(s_resps), 256'(er));
      chk("ord_respack", 256'(s_rack), 256'(1));
    end
    cycle();
    chk("ord_empty", 256'(s_resps), 256'(0));
    top_resp.valid = 0; respacks = '0;

    // Quota: p0 continuous, p1 also requesting; responses keep the FIFO draining.
    reqs[0].bid = 1; reqs[1].bid = 1; top_reqack = 1;
    top_resp.valid = 1; respacks = '1;
    cycle();
    for (int i = 0; i < MAXT; i++) begin
      cycle(); chk("quota_p0_acc", 256'(s_acks), 256'(4'b0001));
    end
    cycle();
`ifdef MUSKBUS_ARB_QUOTA_EN
    chk("quota_bubble", 256'(s_req), 256'(0));
    cycle();
    chk("quota_p1_grant", 256'(s_req.addr), 256'(BASE + 1));
`else
    chk("hold_p0_acc", 256'(s_acks), 256'(4'b0001));
    cycle();
    chk("hold_p0_addr", 256'(s_req.addr), 256'(BASE));
`endif
    drain();

    // Lone master keeps the grant past MAX_TXN accepts.
    reqs[0].bid = 1; top_reqack = 1; top_resp.valid = 1; respacks = '1;
    cycle();
    for (int i = 0; i < MAXT + 2; i++) begin
      cycle(); chk("alone_acc", 256'(s_acks), 256'(4'b0001));
    end
    drain();

    // Reset with two entries outstanding while BUSY.
    reqs[0].bid = 1; top_reqack = 1;
    cycle(); cycle(); cycle();
    top_reqack = 0;
    cycle();
    reqs[1].bid = 1;
    reset = 1; top_resp.valid = 1; top_resp.rdata = 32'hDEAD; respacks = '1;
    cycle();
    reset = 0;
    cycle();
    chk("rst_top_req", 256'(s_req), 256'(0));
    chk("rst_acks", 256'(s_acks), 256'(0));
    chk("rst_resps", 256'(s_resps), 256'(0));
    chk("rst_no_respack", 256'(s_rack), 256'(0));
    cycle();
    chk("rst_p0_wins", 256'(s_req.addr), 256'(BASE));
    drain();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 5) == 0) reqs[i].bid = ~reqs[i].bid;
        reqs[i].wr    = 1'($urandom);
        reqs[i].wdata = $urandom;
      end
      top_reqack     = ($urandom_range(0, 3) != 0);
      top_resp.valid = 1'($urandom);
      top_resp.rdata = $urandom;
      respacks       = N'($urandom);
      reset          = ($urandom_range(0, 149) == 0);
      cycle();
    end
    reset = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muskbus_arbiter.md
# muskbus_arbiter

Parametrised N-to-1 MUSKBUS arbiter that replaces the single-owner mux between N bus masters and one downstream MUSKBUS target. It arbitrates round-robin and holds the grant for a master's burst of requests. Responses are routed back through an in-order outstanding-transaction FIFO, so the grant can move to another master while earlier responses are still in flight. An optional per-grant transaction quota bounds how long one master can hold the bus.

## Interface
- N, 2: number of bottom (master) ports; N ≥ 2.
- OUTSTANDING, 4: depth of the outstanding-response FIFO; power of two, ≥ 2.
- MAX_TXN, 8: accepted requests per grant before a forced release (quota build only); ≥ 1.

- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- bottom_reqs  input  MUSKBUS::req_t[N-1:0]  master requests; `.bid` = request valid.
- bottom_reqacks  output  [N-1:0]  per-master request accept.
- bottom_resps  output  MUSKBUS::resp_t[N-1:0]  routed responses; `.valid` = response valid.
- bottom_respacks  input  [N-1:0]  per-master response accept.
- top_req  output  MUSKBUS::req_t  request to target.
- top_reqack  input  1  target request accept.
- top_resp  input  MUSKBUS::resp_t  target response.
- top_respack  output  1  response accept to target.

## Operation
- Internal widths:
  - owner_ff and FIFO entries: $clog2(N) bits.
  - txn_cnt: $clog2(MAX_TXN+1) bits.
  - FIFO count: $clog2(OUTSTANDING+1) bits.
- States: IDLE, BUSY. Registers: state_ff, owner_ff, last_ff, txn_cnt.
- IDLE:
  - If any bottom_reqs[i].bid is set, select the first requester in the order last_ff+1, last_ff+2, … (mod N).
  - Next cycle: owner_ff = last_ff = selected port, txn_cnt = 0, state = BUSY.
  - If no bid is set, remain in IDLE.
- BUSY request path:
  - top_req = bottom_reqs[owner_ff], with `.bid` forced to 0 while the FIFO is full.
  - bottom_reqacks[owner_ff] = top_reqack & !fifo_full. All other reqacks are 0.
- Accept: a cycle with owner bid & top_reqack & !fifo_full.
  - Push owner_ff into the FIFO.
  - txn_cnt += 1.
- Release from BUSY to IDLE happens at the end of the cycle in which either:
  - the owner's bid is 0; or
  - (quota build only) an accept brings txn_cnt to MAX_TXN and some other port's bid is 1.
- If no other port is requesting when the quota is reached, txn_cnt saturates at MAX_TXN and the grant is held.
- In IDLE, top_req = 0 and all bottom_reqacks = 0.
- Response path (independent of state):
  - If the FIFO is non-empty with head h: bottom_resps[h] = top_resp and top_respack = bottom_respacks[h]. All other bottom_resps are 0.
  - If the FIFO is empty: all bottom_resps = 0 and top_respack = 0.
- Pop: a cycle with top_resp.valid & top_respack. Responses are single-beat and in order.
- Push while full never occurs, because accept is blocked while full even if a pop happens in the same cycle. Simultaneous push and pop when not full leaves the count unchanged.

## Timing
- Reset values:
  - state = IDLE; last_ff = N-1, so port 0 wins the first arbitration; owner_ff = 0; txn_cnt = 0; FIFO empty.
  - All outputs are 0: top_req, top_respack, bottom_reqacks, bottom_resps.
- Reset mid-operation discards all FIFO entries. In-flight target responses are then dropped (top_respack = 0).
- Bid-to-grant latency: a bid seen in IDLE in cycle t is forwarded on top_req in cycle t+1.
- Release-to-regrant: one IDLE bubble cycle after every release.
- The request and response paths are combinational pass-throughs of the registered owner_ff and the FIFO head. There is no added data latency.
- Backpressure: the FIFO holding OUTSTANDING entries blocks further accepts until a pop. Top bid reasserts in the cycle after the pop.

## Configuration
- MUSKBUS_ARB_QUOTA_EN defined:
  - The quota release rule is active. No master holds the grant for more than MAX_TXN accepts while another master is requesting.
- MUSKBUS_ARB_QUOTA_EN undefined:
  - A grant is held until the owner drops bid.
  - txn_cnt and MAX_TXN are unused; the parameter is still accepted.

## Test plan
- N=4, reset, then ports 0 and 2 assert bid together -> port 0 is granted in cycle 1 and port 2 after port 0 drops bid. A subsequent simultaneous bid from 0 and 2 -> port 0 again, since last_ff = 2.
- N=2, OUTSTANDING=4, target acks every cycle, no responses returned -> exactly 4 accepts, then top_req.bid = 0. One response pop -> exactly one further accept.
- Port 0 issues 2 requests, releases; port 1 issues 1 request; target returns 3 responses -> responses arrive at port 0, port 0, port 1 in that order. Other ports see 0.
- Quota build, MAX_TXN=3, port 0 continuous bid, port 1 bids -> port 0 gets 3 accepts, 1 IDLE cycle, then port 1 is granted. Non-quota build -> port 0 holds the grant indefinitely.
- Quota build, port 0 alone with continuous bid -> more than 3 accepts with no release.
- Reset asserted with 2 entries outstanding and BUSY -> next cycle all outputs 0, state IDLE, a returned top_resp is not acked, and port 0 wins the next arbitration.
